// File: rtl/riscv_ram_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_ram_lsu_ctrl
//   Initiator-side controller for a single-port 64-bit data RAM with a
//   combinational read and a synchronous write, and no byte enables.
//   It accepts RV64 load/store requests (B/H/W/D, signed/unsigned) over a
//   valid/ready handshake and turns them into word-indexed RAM accesses.
//   Stores narrower than a doubleword use read-modify-write. Load data is
//   sign- or zero-extended and returned on a registered valid/ready
//   response channel.
//
//   Build option:
//     RISCV_LSU_ALIGN_CHECK_EN
//       When defined, a misaligned access faults.
//       When undefined, the byte lane is aligned down to the access size,
//       and only out-of-range accesses fault.
//
//   All outputs are registers. The output logic computes their values for
//   the next state, so each output changes on the same edge as the FSM.
// ---------------------------------------------------------------------------
module riscv_ram_lsu_ctrl #(
   parameter int                     DATA_WIDTH  = 64,
   parameter int                     DATA_DEPTH  = 4096,
   parameter int                     ADDR_WIDTH  = $clog2(DATA_DEPTH),
   parameter int                     PADDR_WIDTH = 64,
   parameter logic [PADDR_WIDTH-1:0] BASE_ADDR   = 64'h8000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [PADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]             req_size,
   input  logic                   req_unsigned,
   input  logic [DATA_WIDTH-1:0]  req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_WIDTH-1:0]  rsp_rdata,
   output logic                   rsp_err,
   output logic                   ram_we,
   output logic [ADDR_WIDTH-1:0]  ram_addr,
   output logic [DATA_WIDTH-1:0]  ram_wr_data,
   input  logic [DATA_WIDTH-1:0]  ram_rd_data
);

   // Size of the mapped window, in bytes.
   localparam logic [PADDR_WIDTH-1:0] WINDOW_BYTES =
      PADDR_WIDTH'(DATA_DEPTH) * PADDR_WIDTH'(8);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_WRITE  = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   // -------------------------------------------------------------------
   // Helper functions
   // -------------------------------------------------------------------

   // Lane bits that must be zero for a naturally aligned access of this size.
   function automatic logic [2:0] size_mask(input logic [1:0] size);
      logic [2:0] m;
      case (size)
         2'd0:    m = 3'b000;
         2'd1:    m = 3'b001;
         2'd2:    m = 3'b011;
         default: m = 3'b111;
      endcase
      return m;
   endfunction

   // Byte-enable pattern of an access of this size, starting at lane 0.
   function automatic logic [7:0] byte_mask(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   // Take the addressed bytes of a RAM word and extend them to 64 bits.
   function automatic logic [63:0] load_extend(input logic [63:0] word,
                                               input logic [2:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        is_unsigned);
      logic [63:0] sh;
      logic [63:0] res;
      sh = word >> {lane, 3'b000};
      case (size)
         2'd0: res = is_unsigned ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
         2'd1: res = is_unsigned ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
         2'd2: res = is_unsigned ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

   // Place the low bytes of the store data into the old word at the lane.
   // Only the bytes covered by the access size are replaced.
   function automatic logic [63:0] store_merge(input logic [63:0] old_word,
                                               input logic [63:0] wdata,
                                               input logic [2:0]  lane,
                                               input logic [1:0]  size);
      logic [7:0]  bmask;
      logic [63:0] sh;
      logic [63:0] res;
      bmask = byte_mask(size) << lane;
      sh    = wdata << {lane, 3'b000};
      res   = old_word;
      for (int i = 0; i < 8; i++) begin
         if (bmask[i]) begin
            res[i*8 +: 8] = sh[i*8 +: 8];
         end else begin
            res[i*8 +: 8] = old_word[i*8 +: 8];
         end
      end
      return res;
   endfunction

   // -------------------------------------------------------------------
   // Signals
   // -------------------------------------------------------------------
   state_t                  state_r;
   state_t                  state_nxt_s;

   logic [PADDR_WIDTH-1:0]  off_s;
   logic [ADDR_WIDTH-1:0]   idx_s;
   logic [2:0]              lane_raw_s;
   logic [2:0]              lane_s;
   logic                    range_err_s;
   logic                    align_err_s;
   logic                    acc_err_s;
   logic                    accept_s;

   logic [2:0]              lane_r;
   logic [1:0]              size_r;
   logic                    unsigned_r;
   logic [63:0]             wdata_r;

   logic                    req_ready_nxt_s;
   logic                    rsp_valid_nxt_s;
   logic                    rsp_err_nxt_s;
   logic [DATA_WIDTH-1:0]   rsp_rdata_nxt_s;
   logic                    ram_we_nxt_s;
   logic [ADDR_WIDTH-1:0]   ram_addr_nxt_s;
   logic [DATA_WIDTH-1:0]   ram_wr_data_nxt_s;

   // Decode the incoming byte address into a word index, a byte lane and a fault flag.
   always_comb begin
      off_s       = req_addr - BASE_ADDR;
      idx_s       = off_s[ADDR_WIDTH+2:3];
      lane_raw_s  = off_s[2:0];
      range_err_s = (req_addr < BASE_ADDR) || (off_s >= WINDOW_BYTES);
`ifdef RISCV_LSU_ALIGN_CHECK_EN
      align_err_s = ((lane_raw_s & size_mask(req_size)) != 3'd0);
      lane_s      = lane_raw_s;
`else
      align_err_s = 1'b0;
      lane_s      = lane_raw_s & ~size_mask(req_size);
`endif
      acc_err_s   = range_err_s || align_err_s;
      accept_s    = req_valid && req_ready;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (acc_err_s) begin
                  state_nxt_s = ST_RESP;
               end else if (!req_we) begin
                  state_nxt_s = ST_LOAD;
               end else if (req_size == 2'd3) begin
                  state_nxt_s = ST_WRITE;
               end else begin
                  state_nxt_s = ST_RMW_RD;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD:   state_nxt_s = ST_RESP;
         ST_RMW_RD: state_nxt_s = ST_WRITE;
         ST_WRITE:  state_nxt_s = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // Output logic: compute the values the output registers take on the next edge.
   always_comb begin
      req_ready_nxt_s   = (state_nxt_s == ST_IDLE);
      rsp_valid_nxt_s   = (state_nxt_s == ST_RESP);
      ram_we_nxt_s      = (state_nxt_s == ST_WRITE);
      rsp_err_nxt_s     = rsp_err;
      rsp_rdata_nxt_s   = rsp_rdata;
      ram_addr_nxt_s    = ram_addr;
      ram_wr_data_nxt_s = ram_wr_data;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               // Clear the response data here. A store or a fault then returns zero,
               // and a load overwrites the value in LOAD.
               rsp_err_nxt_s   = acc_err_s;
               rsp_rdata_nxt_s = 64'd0;
               if (acc_err_s) begin
                  ram_addr_nxt_s = ram_addr;
               end else begin
                  ram_addr_nxt_s = idx_s;
               end
               // A doubleword store writes req_wdata directly. A narrower store
               // replaces this value with the merged word in RMW_RD.
               if (!acc_err_s && req_we) begin
                  ram_wr_data_nxt_s = req_wdata;
               end else begin
                  ram_wr_data_nxt_s = ram_wr_data;
               end
            end else begin
               rsp_err_nxt_s   = rsp_err;
               rsp_rdata_nxt_s = rsp_rdata;
            end
         end
         ST_LOAD: begin
            rsp_rdata_nxt_s = load_extend(ram_rd_data, lane_r, size_r, unsigned_r);
         end
         ST_RMW_RD: begin
            ram_wr_data_nxt_s = store_merge(ram_rd_data, wdata_r, lane_r, size_r);
         end
         default: begin
            rsp_err_nxt_s = rsp_err;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_rdata   <= 64'd0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wr_data <= 64'd0;
      end else begin
         req_ready   <= req_ready_nxt_s;
         rsp_valid   <= rsp_valid_nxt_s;
         rsp_err     <= rsp_err_nxt_s;
         rsp_rdata   <= rsp_rdata_nxt_s;
         ram_we      <= ram_we_nxt_s;
         ram_addr    <= ram_addr_nxt_s;
         ram_wr_data <= ram_wr_data_nxt_s;
      end
   end

   // Capture the request attributes that LOAD and RMW_RD still need after the accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_r     <= 3'd0;
         size_r     <= 2'd0;
         unsigned_r <= 1'b0;
         wdata_r    <= 64'd0;
      end else if (accept_s && !acc_err_s) begin
         lane_r     <= lane_s;
         size_r     <= req_size;
         unsigned_r <= req_unsigned;
         wdata_r    <= req_wdata;
      end else begin
         lane_r     <= lane_r;
         size_r     <= size_r;
         unsigned_r <= unsigned_r;
         wdata_r    <= wdata_r;
      end
   end

endmodule

// File: tb/tb_riscv_ram_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_ram_lsu_ctrl
//   Directed testbench for riscv_ram_lsu_ctrl with a behavioural 4096 x 64
//   data RAM model. Expected values are computed by hand and written as
//   constants.
// ---------------------------------------------------------------------------
module tb_riscv_ram_lsu_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [63:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic        ram_we;
   logic [11:0] ram_addr;
   logic [63:0] ram_wr_data;
   logic [63:0] ram_rd_data;

   logic [63:0] mem [0:4095];
   int          wr_cnt;
   logic [11:0] last_wr_addr;

   int          err_cnt;
   int          chk_cnt;

   riscv_ram_lsu_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_wr_data  (ram_wr_data),
      .ram_rd_data  (ram_rd_data)
   );

   // Clock generation: 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model: combinational read.
   assign ram_rd_data = mem[ram_addr];

   // RAM model: synchronous write. Also counts the write cycles.
   always @(posedge clk) begin
      if (ram_we === 1'b1) begin
         mem[ram_addr] <= ram_wr_data;
         wr_cnt        <= wr_cnt + 1;
         last_wr_addr  <= ram_addr;
      end
   end

   // Watchdog: stops a run that has hung.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request with rsp_ready held high. Return the latency in edges
   // from the accept edge to the first rsp_valid, plus the response.
   task automatic do_req(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata,
                         output int lat, output logic [63:0] rdata, output logic err);
      int w;
      w = 0;
      while (req_ready !== 1'b1 && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      rsp_ready    = 1'b1;
      req_valid    = 1'b1;
      req_we       = we;
      req_addr     = addr;
      req_size     = size;
      req_unsigned = uns;
      req_wdata    = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      @(posedge clk); #1;
      check_val("hs_valid_drop", 64'(rsp_valid), 64'd0);
      check_val("hs_ready_back", 64'(req_ready), 64'd1);
   endtask

   int          lat;
   logic [63:0] rd;
   logic        er;
   int          wc0;

   initial begin
      err_cnt = 0;
      chk_cnt = 0;
      wr_cnt  = 0;
      last_wr_addr = 12'd0;
      for (int i = 0; i < 4096; i++) mem[i] = 64'd0;
      mem[0]    = 64'h0000_0000_0000_C3A5;
      mem[4095] = 64'hA5A5_0000_FFFF_1234;
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 64'd0; req_size = 2'd0;
      req_unsigned = 1'b0; req_wdata = 64'd0; rsp_ready = 1'b1;

      // Reset state.
      #12;
      check_val("rst_req_ready", 64'(req_ready), 64'd1);
      check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_val("rst_rsp_err",   64'(rsp_err),   64'd0);
      check_val("rst_rsp_rdata", rsp_rdata,      64'd0);
      check_val("rst_ram_we",    64'(ram_we),    64'd0);
      check_val("rst_ram_addr",  64'(ram_addr),  64'd0);
      check_val("rst_ram_wdata", ram_wr_data,    64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Store D to word 2.
      wc0 = wr_cnt;
      do_req(1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'h1122_3344_5566_7788, lat, rd, er);
      check_val("stD_lat",    64'(lat), 64'd2);
      check_val("stD_err",    64'(er),  64'd0);
      check_val("stD_rdata",  rd,       64'd0);
      check_val("stD_nwr",    64'(wr_cnt - wc0), 64'd1);
      check_val("stD_waddr",  64'(last_wr_addr), 64'd2);
      check_val("stD_mem",    mem[2], 64'h1122_3344_5566_7788);

      // Load D of word 2.
      wc0 = wr_cnt;
      do_req(1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'd0, lat, rd, er);
      check_val("ldD_lat",   64'(lat), 64'd2);
      check_val("ldD_err",   64'(er),  64'd0);
      check_val("ldD_rdata", rd,       64'h1122_3344_5566_7788);
      check_val("ldD_nwr",   64'(wr_cnt - wc0), 64'd0);

      // Store B to lane 3 with read-modify-write. The upper data bytes must be ignored.
      wc0 = wr_cnt;
      do_req(1'b1, 64'h8000_0013, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_CDAB, lat, rd, er);
      check_val("stB_lat",  64'(lat), 64'd3);
      check_val("stB_err",  64'(er),  64'd0);
      check_val("stB_nwr",  64'(wr_cnt - wc0), 64'd1);
      check_val("stB_mem",  mem[2], 64'h1122_3344_AB66_7788);

      // Load B signed and unsigned from lane 3.
      do_req(1'b0, 64'h8000_0013, 2'd0, 1'b0, 64'd0, lat, rd, er);
      check_val("ldBs_lat",   64'(lat), 64'd2);
      check_val("ldBs_rdata", rd, 64'hFFFF_FFFF_FFFF_FFAB);
      do_req(1'b0, 64'h8000_0013, 2'd0, 1'b1, 64'd0, lat, rd, er);
      check_val("ldBu_rdata", rd, 64'h0000_0000_0000_00AB);

      // Load W signed and unsigned from lane 4.
      do_req(1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'h8000_0001_0000_0000, lat, rd, er);
      do_req(1'b0, 64'h8000_0014, 2'd2, 1'b0, 64'd0, lat, rd, er);
      check_val("ldWs_rdata", rd, 64'hFFFF_FFFF_8000_0001);
      check_val("ldWs_err",   64'(er), 64'd0);
      do_req(1'b0, 64'h8000_0014, 2'd2, 1'b1, 64'd0, lat, rd, er);
      check_val("ldWu_rdata", rd, 64'h0000_0000_8000_0001);

      // Store H to lane 2 and store W to lane 4 of word 3.
      do_req(1'b1, 64'h8000_0012, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_1234, lat, rd, er);
      check_val("stH_lat", 64'(lat), 64'd3);
      check_val("stH_mem", mem[2], 64'h8000_0001_1234_0000);
      do_req(1'b1, 64'h8000_001C, 2'd2, 1'b0, 64'h0123_4567_DEAD_BEEF, lat, rd, er);
      check_val("stW_mem", mem[3], 64'hDEAD_BEEF_0000_0000);
      do_req(1'b0, 64'h8000_001C, 2'd2, 1'b1, 64'd0, lat, rd, er);
      check_val("ldW3_rdata", rd, 64'h0000_0000_DEAD_BEEF);

      // Last word of the window is still in range.
      do_req(1'b0, 64'h8000_7FF8, 2'd3, 1'b0, 64'd0, lat, rd, er);
      check_val("ldLast_err",   64'(er), 64'd0);
      check_val("ldLast_rdata", rd, 64'hA5A5_0000_FFFF_1234);
      do_req(1'b0, 64'h8000_7FFF, 2'd0, 1'b1, 64'd0, lat, rd, er);
      check_val("ldLastB_rdata", rd, 64'h0000_0000_0000_00A5);

      // Out-of-range accesses below and above the window.
      wc0 = wr_cnt;
      do_req(1'b0, 64'h7FFF_FFF8, 2'd3, 1'b0, 64'd0, lat, rd, er);
      check_val("errLo_lat",   64'(lat), 64'd1);
      check_val("errLo_err",   64'(er),  64'd1);
      check_val("errLo_rdata", rd,       64'd0);
      do_req(1'b0, 64'h8000_8000, 2'd3, 1'b0, 64'd0, lat, rd, er);
      check_val("errHi_lat",   64'(lat), 64'd1);
      check_val("errHi_err",   64'(er),  64'd1);
      check_val("errHi_rdata", rd,       64'd0);
      do_req(1'b1, 64'h8000_8000, 2'd3, 1'b0, 64'hDEAD_DEAD_DEAD_DEAD, lat, rd, er);
      check_val("errSt_err", 64'(er), 64'd1);
      check_val("err_nwr",   64'(wr_cnt - wc0), 64'd0);

      // Misaligned halfword at lane 1.
      do_req(1'b0, 64'h8000_0001, 2'd1, 1'b0, 64'd0, lat, rd, er);
`ifdef RISCV_LSU_ALIGN_CHECK_EN
      check_val("misH_lat",   64'(lat), 64'd1);
      check_val("misH_err",   64'(er),  64'd1);
      check_val("misH_rdata", rd,       64'd0);
`else
      check_val("misH_lat",   64'(lat), 64'd2);
      check_val("misH_err",   64'(er),  64'd0);
      check_val("misH_rdata", rd,       64'hFFFF_FFFF_FFFF_C3A5);
`endif

      // Backpressure: hold rsp_ready low for 5 cycles during a load response.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_0010;
      req_size = 2'd3; req_unsigned = 1'b0; req_wdata = 64'd0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check_val("bp_valid", 64'(rsp_valid), 64'd1);
         check_val("bp_rdata", rsp_rdata, 64'h8000_0001_1234_0000);
         check_val("bp_ready", 64'(req_ready), 64'd0);
         @(posedge clk); #1;
      end
      check_val("bp_valid_end", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check_val("bp_drop",  64'(rsp_valid), 64'd0);
      check_val("bp_ready_back", 64'(req_ready), 64'd1);

      // Reset during RMW_RD of a byte store: the word must stay unchanged.
      wc0 = wr_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h8000_0010;
      req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 64'h0000_0000_0000_0055;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_val("mid_ready_busy", 64'(req_ready), 64'd0);
      rst = 1'b1;
      #1;
      check_val("mid_req_ready", 64'(req_ready), 64'd1);
      check_val("mid_rsp_valid", 64'(rsp_valid), 64'd0);
      check_val("mid_ram_we",    64'(ram_we),    64'd0);
      check_val("mid_ram_addr",  64'(ram_addr),  64'd0);
      check_val("mid_ram_wdata", ram_wr_data,    64'd0);
      check_val("mid_rsp_rdata", rsp_rdata,      64'd0);
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_val("mid_nwr", 64'(wr_cnt - wc0), 64'd0);
      check_val("mid_mem", mem[2], 64'h8000_0001_1234_0000);
      do_req(1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'd0, lat, rd, er);
      check_val("post_lat",   64'(lat), 64'd2);
      check_val("post_rdata", rd, 64'h8000_0001_1234_0000);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
